// File: rtl/accelerator_precedence_weighting_pkg.sv
// Shared definitions for the precedence-weighting update stage:
// FSM state encodings and fixed-point data constants.
package accelerator_precedence_weighting_pkg;

  localparam logic [2:0] STARTER_ST = 3'd0;
  localparam logic [2:0] SUM_ST     = 3'd1;
  localparam logic [2:0] SCALE_ST   = 3'd2;
  localparam logic [2:0] UPDATE_ST  = 3'd3;
  localparam logic [2:0] OUTPUT_ST  = 3'd4;

  localparam int DEFAULT_DATA_SIZE = 64;

  // ONE_DATA is 1.0 for the default 64-bit datapath (32 fraction bits).
  localparam logic [63:0] ZERO_DATA = 64'h0000_0000_0000_0000;
  localparam logic [63:0] ONE_DATA  = 64'h0000_0001_0000_0000;

endpackage

// File: rtl/accelerator_precedence_weighting_mac.sv
// Fixed-point p' = (scale * p >> F) + w with saturation at all-ones.
module accelerator_precedence_weighting_mac
  import accelerator_precedence_weighting_pkg::*;
#(
  parameter int DATA_SIZE = 64
) (
  input  logic [DATA_SIZE-1:0] scale,
  input  logic [DATA_SIZE-1:0] p_prev,
  input  logic [DATA_SIZE-1:0] w_curr,
  output logic [DATA_SIZE-1:0] p_next
);

  localparam int F_BITS = DATA_SIZE / 2;

  logic [2*DATA_SIZE-1:0] prod_s;
  logic [2*DATA_SIZE-1:0] shifted_s;
  logic                   prod_ovf_s;
  logic [DATA_SIZE:0]     add_s;

  // Widen, multiply, drop the fraction, then saturating add of w.
  always_comb begin
    prod_s     = {{DATA_SIZE{1'b0}}, scale} * {{DATA_SIZE{1'b0}}, p_prev};
    shifted_s  = prod_s >> F_BITS;
    prod_ovf_s = |shifted_s[2*DATA_SIZE-1:DATA_SIZE];
    add_s      = {1'b0, shifted_s[DATA_SIZE-1:0]} + {1'b0, w_curr};
    if (prod_ovf_s || add_s[DATA_SIZE]) begin
      p_next = {DATA_SIZE{1'b1}};
    end else begin
      p_next = add_s[DATA_SIZE-1:0];
    end
  end

endmodule

// File: rtl/accelerator_precedence_weighting.sv
// Precedence update p(t)[j] = (1 - sum w(t)) * p(t-1)[j] + w(t)[j],
// streamed element by element with request/strobe handshakes.
module accelerator_precedence_weighting
  import accelerator_precedence_weighting_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 W_IN_ENABLE,
  input  logic                 P_IN_ENABLE,
  output logic                 W_OUT_ENABLE,
  output logic                 P_OUT_ENABLE,
  output logic                 P_OUT_J_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_N_IN,
  input  logic [DATA_SIZE-1:0] W_IN,
  input  logic [DATA_SIZE-1:0] P_IN,
  output logic [DATA_SIZE-1:0] P_OUT
);

  localparam int F_BITS = DATA_SIZE / 2;
  localparam int IDX_W  = (CONTROL_SIZE > DATA_SIZE) ? CONTROL_SIZE : DATA_SIZE;
  localparam logic [DATA_SIZE-1:0] ZERO_C = DATA_SIZE'(ZERO_DATA);
  localparam logic [DATA_SIZE-1:0] ONE_C  = (DATA_SIZE == DEFAULT_DATA_SIZE) ?
                                            DATA_SIZE'(ONE_DATA) :
                                            (DATA_SIZE'(1) << F_BITS);

  logic [2:0]              state_r;
  logic [DATA_SIZE-1:0]    n_r;
  logic [CONTROL_SIZE-1:0] index_r;
  logic [DATA_SIZE-1:0]    sum_r;
  logic [DATA_SIZE-1:0]    scale_r;
  logic [DATA_SIZE-1:0]    w_r;
  logic [DATA_SIZE-1:0]    p_r;
  logic                    w_flag_r;
  logic                    p_flag_r;
  logic                    ready_r;
  logic                    w_req_r;
  logic                    p_req_r;
  logic                    p_j_r;
  logic [DATA_SIZE-1:0]    p_out_r;

  logic [DATA_SIZE:0]      sum_wide_s;
  logic [DATA_SIZE-1:0]    sum_next_s;
  logic [DATA_SIZE-1:0]    scale_next_s;
  logic [DATA_SIZE-1:0]    mac_s;
  logic                    last_s;
  logic                    n_zero_s;
  logic                    both_s;

  // Combinational helpers: saturating sum, scale, last-element detect.
  always_comb begin
    sum_wide_s = {1'b0, sum_r} + {1'b0, W_IN};
    if (sum_wide_s[DATA_SIZE]) begin
      sum_next_s = {DATA_SIZE{1'b1}};
    end else begin
      sum_next_s = sum_wide_s[DATA_SIZE-1:0];
    end
    if (sum_r <= ONE_C) begin
      scale_next_s = ONE_C - sum_r;
    end else begin
      scale_next_s = ZERO_C;
    end
    last_s   = (IDX_W'(index_r) == (IDX_W'(n_r) - IDX_W'(1)));
    n_zero_s = (SIZE_N_IN == ZERO_C);
    both_s   = w_flag_r && p_flag_r;
  end

  accelerator_precedence_weighting_mac #(
    .DATA_SIZE(DATA_SIZE)
  ) u_mac (
    .scale (scale_r),
    .p_prev(p_r),
    .w_curr(w_r),
    .p_next(mac_s)
  );

  // FSM sequencing, vector length and element index.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= STARTER_ST;
      n_r     <= ZERO_C;
      index_r <= '0;
    end else begin
      case (state_r)
        STARTER_ST: begin
          if (START) begin
            n_r     <= SIZE_N_IN;
            index_r <= '0;
            if (!n_zero_s) begin
              state_r <= SUM_ST;
            end
          end
        end
        SUM_ST: begin
          if (W_IN_ENABLE) begin
            if (last_s) begin
              state_r <= SCALE_ST;
            end else begin
              index_r <= index_r + CONTROL_SIZE'(1);
            end
          end
        end
        SCALE_ST: begin
          index_r <= '0;
          state_r <= UPDATE_ST;
        end
        UPDATE_ST: begin
          if (both_s) begin
            state_r <= OUTPUT_ST;
          end
        end
        OUTPUT_ST: begin
          if (last_s) begin
            state_r <= STARTER_ST;
          end else begin
            index_r <= index_r + CONTROL_SIZE'(1);
            state_r <= UPDATE_ST;
          end
        end
        default: begin
          state_r <= STARTER_ST;
        end
      endcase
    end
  end

  // Weight-sum accumulation and the derived retention scale.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sum_r   <= ZERO_C;
      scale_r <= ZERO_C;
    end else begin
      case (state_r)
        STARTER_ST: begin
          if (START) begin
            sum_r <= ZERO_C;
          end
        end
        SUM_ST: begin
          if (W_IN_ENABLE) begin
            sum_r <= sum_next_s;
          end
        end
        SCALE_ST: begin
          scale_r <= scale_next_s;
        end
        default: begin
          sum_r <= sum_r;
        end
      endcase
    end
  end

  // Per-element operand capture; the first strobe of each input wins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      w_r      <= ZERO_C;
      p_r      <= ZERO_C;
      w_flag_r <= 1'b0;
      p_flag_r <= 1'b0;
    end else begin
      case (state_r)
        UPDATE_ST: begin
          if (W_IN_ENABLE && !w_flag_r) begin
            w_r      <= W_IN;
            w_flag_r <= 1'b1;
          end
          if (P_IN_ENABLE && !p_flag_r) begin
            p_r      <= P_IN;
            p_flag_r <= 1'b1;
          end
        end
        default: begin
          w_flag_r <= 1'b0;
          p_flag_r <= 1'b0;
        end
      endcase
    end
  end

  // Registered outputs: single-cycle pulses plus the held P_OUT value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ready_r <= 1'b0;
      w_req_r <= 1'b0;
      p_req_r <= 1'b0;
      p_j_r   <= 1'b0;
      p_out_r <= ZERO_C;
    end else begin
      ready_r <= 1'b0;
      w_req_r <= 1'b0;
      p_req_r <= 1'b0;
      p_j_r   <= 1'b0;
      case (state_r)
        STARTER_ST: begin
          if (START) begin
            ready_r <= n_zero_s;
            w_req_r <= !n_zero_s;
          end
        end
        SUM_ST: begin
          w_req_r <= W_IN_ENABLE && !last_s;
        end
        SCALE_ST: begin
          w_req_r <= 1'b1;
          p_req_r <= 1'b1;
        end
        UPDATE_ST: begin
          if (both_s) begin
            p_out_r <= mac_s;
            p_j_r   <= 1'b1;
            ready_r <= last_s;
          end
        end
        OUTPUT_ST: begin
          w_req_r <= !last_s;
          p_req_r <= !last_s;
        end
        default: begin
          p_out_r <= p_out_r;
        end
      endcase
    end
  end

  assign READY          = ready_r;
  assign W_OUT_ENABLE   = w_req_r;
  assign P_OUT_ENABLE   = p_req_r;
  assign P_OUT_J_ENABLE = p_j_r;
  assign P_OUT          = p_out_r;

endmodule

// File: tb/tb_accelerator_precedence_weighting.sv
// Randomised scoreboard bench for accelerator_precedence_weighting (16-bit, ONE = 0x0100).
module tb_accelerator_precedence_weighting;

  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START = 1'b0;
  logic          W_IN_ENABLE = 1'b0;
  logic          P_IN_ENABLE = 1'b0;
  logic [DW-1:0] SIZE_N_IN = '0;
  logic [DW-1:0] W_IN = '0;
  logic [DW-1:0] P_IN = '0;
  logic          READY, W_OUT_ENABLE, P_OUT_ENABLE, P_OUT_J_ENABLE;
  logic [DW-1:0] P_OUT;

  typedef struct {
    int data;
    int last;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   n0_expect = 1'b0;
  int   wv[8];
  int   pv[8];

  accelerator_precedence_weighting #(.DATA_SIZE(DW), .CONTROL_SIZE(DW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .W_IN_ENABLE(W_IN_ENABLE), .P_IN_ENABLE(P_IN_ENABLE),
    .W_OUT_ENABLE(W_OUT_ENABLE), .P_OUT_ENABLE(P_OUT_ENABLE),
    .P_OUT_J_ENABLE(P_OUT_J_ENABLE), .SIZE_N_IN(SIZE_N_IN),
    .W_IN(W_IN), .P_IN(P_IN), .P_OUT(P_OUT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: fixed point with 8 fraction bits, plain integer arithmetic.
  function automatic int model_p(input int n, input int j);
    longint s, sc, r;
    s = 0;
    for (int i = 0; i < n; i++) s += wv[i];
    if (s > 65535) s = 65535;
    sc = (s <= 256) ? (256 - s) : 0;
    r = ((sc * pv[j]) / 256) + wv[j];
    if (r > 65535) r = 65535;
    return int'(r);
  endfunction

  // Monitor: pops the scoreboard on every P_OUT_J_ENABLE.
  initial begin : monitor
    exp_t e;
    int   last_exp;
    last_exp = 0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        last_exp = 0;
      end else if (P_OUT_J_ENABLE) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pout: actual=%0h expected=none", P_OUT);
        end else begin
          e = sb_q.pop_front();
          checki("pout_data", int'(P_OUT), e.data);
          checki("ready_with_last", int'(READY), e.last);
          checki("pout_latency", cyc, e.cyc);
          last_exp = e.data;
        end
      end else begin
        checki("pout_hold", int'(P_OUT), last_exp);
        if (READY) checki("stray_ready", int'(n0_expect), 1);
      end
    end
  end

  task automatic wait_req(input bit need_p);
    int k;
    k = 0;
    while (!(W_OUT_ENABLE && (P_OUT_ENABLE || !need_p)) && k < 20) begin
      @(negedge CLK);
      k++;
    end
    checki(need_p ? "req_wp_timeout" : "req_w_timeout", int'(k < 20), 1);
    if (!need_p) checki("sum_no_p_req", int'(P_OUT_ENABLE), 0);
  endtask

  task automatic do_start(input int n);
    @(negedge CLK);
    START = 1'b1;
    SIZE_N_IN = DW'(n);
    @(negedge CLK);
    START = 1'b0;
    SIZE_N_IN = DW'($urandom);
  endtask

  task automatic do_sum(input int n);
    for (int i = 0; i < n; i++) begin
      wait_req(1'b0);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      W_IN_ENABLE = 1'b1;
      W_IN = DW'(wv[i]);
      P_IN_ENABLE = 1'($urandom_range(0, 1));
      P_IN = DW'($urandom);
      @(negedge CLK);
      W_IN_ENABLE = 1'b0;
      P_IN_ENABLE = 1'b0;
      W_IN = DW'($urandom);
    end
  endtask

  // mode 0: random W/P skew and stray strobes; mode 1: P three cycles before W plus a duplicate P.
  task automatic do_update(input int n, input int mode);
    int dw, dp, lat;
    bit dup_p;
    exp_t e;
    for (int j = 0; j < n; j++) begin
      wait_req(1'b1);
      if (mode == 1) begin
        dp = 0; dw = 3; dup_p = 1'b1;
      end else begin
        dw = $urandom_range(0, 3);
        dp = $urandom_range(0, 3);
        dup_p = ($urandom_range(0, 2) == 0);
      end
      lat = (dw > dp) ? dw : dp;
      for (int c = 0; c <= lat + 1; c++) begin
        W_IN_ENABLE = (c == dw);
        W_IN = (c == dw) ? DW'(wv[j]) : DW'($urandom);
        P_IN_ENABLE = (c == dp) || (dup_p && c == dp + 1);
        P_IN = (c == dp) ? DW'(pv[j]) : DW'($urandom);
        START = (mode == 0) && (c == 0) && ($urandom_range(0, 3) == 0);
        SIZE_N_IN = DW'($urandom);
        if (c == lat) begin
          e.data = model_p(n, j);
          e.last = (j == n - 1) ? 1 : 0;
          e.cyc = cyc + 2;
          sb_q.push_back(e);
        end
        @(negedge CLK);
      end
      W_IN_ENABLE = 1'b0;
      P_IN_ENABLE = 1'b0;
      START = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 30) begin
      @(negedge CLK);
      k++;
    end
    checki("drain_timeout", int'(k < 30), 1);
    sb_q.delete();
    repeat (2) @(negedge CLK);
  endtask

  task automatic run_pass(input int n, input int mode);
    do_start(n);
    do_sum(n);
    do_update(n, mode);
    drain();
  endtask

  task automatic check_idle_outputs(input string nm);
    checki({nm, "_ready"}, int'(READY), 0);
    checki({nm, "_wreq"}, int'(W_OUT_ENABLE), 0);
    checki({nm, "_preq"}, int'(P_OUT_ENABLE), 0);
    checki({nm, "_pj"}, int'(P_OUT_J_ENABLE), 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check_idle_outputs("reset");
    checki("reset_pout", int'(P_OUT), 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    wv[0] = 'h0040; wv[1] = 'h0040; pv[0] = 'h0100; pv[1] = 'h0000;
    run_pass(2, 0);
    wv[0] = 'h00C0; wv[1] = 'h00C0; pv[0] = 'h0100; pv[1] = 'h0080;
    run_pass(2, 0);
    wv[0] = 'h0001; pv[0] = 'hFFFF;
    run_pass(1, 0);

    // N = 0: READY the cycle after START, nothing else.
    @(negedge CLK);
    START = 1'b1;
    SIZE_N_IN = '0;
    n0_expect = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    checki("n0_ready", int'(READY), 1);
    checki("n0_wreq", int'(W_OUT_ENABLE), 0);
    repeat (4) begin
      @(negedge CLK);
      check_idle_outputs("n0_after");
    end
    n0_expect = 1'b0;

    wv[0] = 'h0030; wv[1] = 'h0050; pv[0] = 'h1234; pv[1] = 'h0ABC;
    run_pass(2, 1);

    // Reset in the middle of UPDATE aborts the pass silently.
    wv[0] = 'h0010; wv[1] = 'h0020; pv[0] = 'h0200; pv[1] = 'h0300;
    do_start(2);
    do_sum(2);
    wait_req(1'b1);
    W_IN_ENABLE = 1'b1;
    W_IN = DW'(wv[0]);
    @(negedge CLK);
    W_IN_ENABLE = 1'b0;
    RST = 1'b0;
    #1;
    check_idle_outputs("midreset");
    checki("midreset_pout", int'(P_OUT), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check_idle_outputs("post_reset");
    end
    wv[0] = 'h0080; pv[0] = 'h0100;
    run_pass(1, 0);

    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        wv[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 128));
        pv[i] = int'($urandom_range(0, 65535));
      end
      run_pass(n, ($urandom_range(0, 4) == 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/accelerator_precedence_weighting.md
ACCELERATOR_PRECEDENCE_WEIGHTING -- requirements
Module: accelerator_precedence_weighting

Interface
REQ-001 Parameter DATA_SIZE, default 64, is the width of every data port and internal datapath register.
REQ-002 Parameter CONTROL_SIZE, default 64, is the width of the element index counter.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-low.
REQ-005 START  input  1  one-cycle pulse that begins an update pass.
REQ-006 READY  output  1  one-cycle pulse when the pass completes.
REQ-007 W_IN_ENABLE  input  1  strobe: W_IN holds write-weighting element w(t)[j].
REQ-008 P_IN_ENABLE  input  1  strobe: P_IN holds previous precedence element p(t-1)[j].
REQ-009 W_OUT_ENABLE  output  1  one-cycle request for the next W_IN element.
REQ-010 P_OUT_ENABLE  output  1  one-cycle request for the next P_IN element.
REQ-011 P_OUT_J_ENABLE  output  1  strobe: P_OUT holds p(t)[j].
REQ-012 SIZE_N_IN  input  DATA_SIZE  vector length N, sampled on START.
REQ-013 W_IN, P_IN  input  DATA_SIZE  element data.
REQ-014 P_OUT  output  DATA_SIZE  updated precedence element, sent to the temporal link matrix stage.

Function
REQ-015 The block SHALL compute p(t)[j] = (1 - sum_i w(t)[i]) * p(t-1)[j] + w(t)[j] for j = 0..N-1.
REQ-016 Arithmetic SHALL be unsigned fixed point with F = DATA_SIZE/2 fraction bits, so ONE = 2^F.
REQ-017 Products SHALL be formed at 2*DATA_SIZE width and shifted right by F, truncating toward zero.
REQ-018 Sum accumulation and the final addition SHALL saturate at all-ones.
REQ-019 Scale = ONE - sum when sum <= ONE; otherwise scale = 0.
REQ-020 FSM states: STARTER, SUM, SCALE, UPDATE, OUTPUT.
REQ-021 STARTER: on START, latch N, clear sum and index. If N = 0, pulse READY next cycle and stay in STARTER; otherwise go to SUM.
REQ-022 SUM: pulse W_OUT_ENABLE on entry and after each accepted W_IN_ENABLE; add W_IN to sum. After the N-th element, go to SCALE.
REQ-023 SCALE: compute scale in one cycle, reset index to 0, then go to UPDATE.
REQ-024 UPDATE: pulse W_OUT_ENABLE and P_OUT_ENABLE together on entry. Hold a per-element flag for each input. W and P MAY arrive in the same or in different cycles, and the second arrival of an already-flagged input SHALL be ignored.
REQ-025 When both flags are set, go to OUTPUT.
REQ-026 OUTPUT: drive P_OUT and pulse P_OUT_J_ENABLE for exactly one cycle. If index = N-1, pulse READY in the same cycle and go to STARTER; otherwise increment index and return to UPDATE.
REQ-027 Latency per element SHALL be 2 cycles after the later of the W/P strobes.
REQ-028 START SHALL be ignored outside STARTER.
REQ-029 P_OUT SHALL hold its last value between strobes.
REQ-030 Input strobes arriving in a state that does not request them SHALL be ignored.

Reset
REQ-031 While RST = 0, the FSM SHALL be in STARTER, all outputs 0, and sum, scale, index and flags cleared.
REQ-032 Reset asserted mid-pass SHALL abort the pass without a READY pulse; the next pass requires a new START.

Structure
REQ-033 The state encodings and the ZERO_DATA/ONE_DATA constants SHALL reside in the shared accelerator package.
REQ-034 The fixed-point multiply-add SHALL be one sub-module, accelerator_precedence_weighting_mac (combinational, DATA_SIZE-parameterised); there SHALL be no other instances.

Verification (DATA_SIZE = 16, ONE = 0x0100)
REQ-035 N=2, W=[0x0040,0x0040], P=[0x0100,0x0000] -> P_OUT 0x00C0 then 0x0040; READY with the second strobe.
REQ-036 N=2, W=[0x00C0,0x00C0] (sum 0x0180, scale 0), P=[0x0100,0x0080] -> P_OUT 0x00C0, 0x00C0.
REQ-037 N=1, W=0x0001, P=0xFFFF -> scale 0x00FF, P_OUT 0xFF00.
REQ-038 N=0 -> READY one cycle after START; no W/P requests and no P_OUT_J_ENABLE.
REQ-039 P strobe 3 cycles before W in UPDATE, plus a duplicate P strobe -> a single correct P_OUT, 2 cycles after the W strobe.
REQ-040 RST low during UPDATE -> all outputs 0, no READY; a new START with N=1 then completes normally.
